// File: rtl/io_dma_master_if.sv
// Data-memory/IO bus driven by the DMA initiator: byte address, write data,
// write enable, and the already-muxed read data returned by DRAM/IO.
interface io_dma_master_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/io_dma_master.sv
// Word-block copy engine between DRAM (0x00-0x7F) and IO (0x80-0xFF) space.
// Optional running checksum of written words when IO_DMA_CHECKSUM_EN is defined.
module io_dma_master #(
  parameter int RD_LAT    = 1,
  parameter int MAX_CNT_W = 6
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [MAX_CNT_W-1:0] count,
  output logic                 busy,
  output logic                 done,
  io_dma_master_if.master      bus
`ifdef IO_DMA_CHECKSUM_EN
  ,
  output logic [31:0]          csum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WAIT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(RD_LAT);
  localparam logic [MAX_CNT_W-1:0] CNT_ZERO  = {MAX_CNT_W{1'b0}};
  localparam logic [MAX_CNT_W-1:0] CNT_ONE   = MAX_CNT_W'(1);

  state_t                state_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  mem_we_r;
  logic [31:0]           mem_addr_r;
  logic [31:0]           data_reg_r;
  logic [31:0]           src_ptr_r;
  logic [31:0]           dst_ptr_r;
  logic [MAX_CNT_W-1:0]  remain_r;
  logic [WAIT_W-1:0]     wait_r;
`ifdef IO_DMA_CHECKSUM_EN
  logic [31:0]           csum_r;
`endif

  // Transfer sequencer; every bus output is set here for the state being entered.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      data_reg_r <= 32'h0000_0000;
      src_ptr_r  <= 32'h0000_0000;
      dst_ptr_r  <= 32'h0000_0000;
      remain_r   <= CNT_ZERO;
      wait_r     <= {WAIT_W{1'b0}};
`ifdef IO_DMA_CHECKSUM_EN
      csum_r     <= 32'h0000_0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          mem_we_r <= 1'b0;
          done_r   <= 1'b0;
          wait_r   <= {WAIT_W{1'b0}};
          if (start) begin
            src_ptr_r <= src_addr & 32'hFFFF_FFFC;
            dst_ptr_r <= dst_addr & 32'hFFFF_FFFC;
            remain_r  <= count;
            busy_r    <= 1'b1;
`ifdef IO_DMA_CHECKSUM_EN
            csum_r    <= 32'h0000_0000;
`endif
            if (count == CNT_ZERO) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= RD;
              mem_addr_r <= src_addr & 32'hFFFF_FFFC;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        RD: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            wait_r  <= {WAIT_W{1'b0}};
          end else if (wait_r == WAIT_LAST) begin
            // Read data is valid on the last wait cycle; it becomes the write data.
            data_reg_r <= bus.mem_rdata;
            mem_addr_r <= dst_ptr_r;
            mem_we_r   <= 1'b1;
            wait_r     <= {WAIT_W{1'b0}};
            state_r    <= WR;
          end else begin
            wait_r <= wait_r + WAIT_W'(1);
          end
        end
        WR: begin
          mem_we_r  <= 1'b0;
          src_ptr_r <= src_ptr_r + 32'd4;
          dst_ptr_r <= dst_ptr_r + 32'd4;
          remain_r  <= remain_r - CNT_ONE;
`ifdef IO_DMA_CHECKSUM_EN
          csum_r    <= csum_r + data_reg_r;
`endif
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (remain_r == CNT_ONE) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r    <= RD;
            mem_addr_r <= src_ptr_r + 32'd4;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
          mem_we_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = data_reg_r;
  assign bus.mem_we    = mem_we_r;
`ifdef IO_DMA_CHECKSUM_EN
  assign csum          = csum_r;
`endif

endmodule

// File: tb/tb_io_dma_master.sv
// Directed bench for io_dma_master with a 64-word synchronous memory model.
module tb_io_dma_master;
  logic        clock = 1'b0;
  logic        resetn, start, abort;
  logic [31:0] src_addr, dst_addr;
  logic [5:0]  count;
  logic        busy, done;
`ifdef IO_DMA_CHECKSUM_EN
  logic [31:0] csum;
`endif

  always #5 clock = ~clock;

  io_dma_master_if bus_if ();

  io_dma_master #(.RD_LAT(1), .MAX_CNT_W(6)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .bus      (bus_if)
`ifdef IO_DMA_CHECKSUM_EN
    ,
    .csum     (csum)
`endif
  );

  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_val = 32'd0;
  int we_cnt = 0, done_cnt = 0, cyc = 0, we_last = 0, we_prev = 0;
  int tests = 0, fails = 0;

  // Memory model (1-cycle read latency) plus write/done event counters.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_idx] <= poke_val;
    if (bus_if.mem_we) begin
      mem[bus_if.mem_addr[7:2]] <= bus_if.mem_wdata;
      we_cnt  <= we_cnt + 1;
      we_prev <= we_last;
      we_last <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
    bus_if.mem_rdata <= mem[bus_if.mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clock);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [5:0] c);
    @(negedge clock);
    start = 1'b1; src_addr = s; dst_addr = d; count = c;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int w0, d0, seen;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = 32'd0; dst_addr = 32'd0; count = 6'd0;

    // Reset then idle
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_we",   32'(bus_if.mem_we), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_addr", bus_if.mem_addr, 32'd0);
    end
    check("rst_wdata", bus_if.mem_wdata, 32'd0);

    // Single-word copy DRAM 0x10 -> IO 0x80
    poke(6'd4, 32'hDEADBEEF);
    go(32'h10, 32'h80, 6'd1);
    check("sw_rd1_addr", bus_if.mem_addr, 32'h10);
    check("sw_rd1_we",   32'(bus_if.mem_we), 32'd0);
    check("sw_rd1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("sw_rd2_addr", bus_if.mem_addr, 32'h10);
    check("sw_rd2_we",   32'(bus_if.mem_we), 32'd0);
    @(negedge clock);
    check("sw_wr_addr",  bus_if.mem_addr, 32'h80);
    check("sw_wr_data",  bus_if.mem_wdata, 32'hDEADBEEF);
    check("sw_wr_we",    32'(bus_if.mem_we), 32'd1);
    check("sw_wr_done",  32'(done), 32'd0);
    @(negedge clock);
    check("sw_done",     32'(done), 32'd1);
    check("sw_done_busy", 32'(busy), 32'd1);
    check("sw_done_we",  32'(bus_if.mem_we), 32'd0);
    @(negedge clock);
    check("sw_end_done", 32'(done), 32'd0);
    check("sw_end_busy", 32'(busy), 32'd0);
    check("sw_hold_addr", bus_if.mem_addr, 32'h80);
    check("sw_mem",      mem[32], 32'hDEADBEEF);

    // Block copy IO -> DRAM, 3 words
    poke(6'd32, 32'h11);
    poke(6'd33, 32'h22);
    poke(6'd34, 32'h33);
    w0 = we_cnt; d0 = done_cnt;
    go(32'h80, 32'h00, 6'd3);
    wait_idle(40);
    @(negedge clock);
    check("blk_mem0", mem[0], 32'h11);
    check("blk_mem1", mem[1], 32'h22);
    check("blk_mem2", mem[2], 32'h33);
    check("blk_wecnt", 32'(we_cnt - w0), 32'd3);
    check("blk_space", 32'(we_last - we_prev), 32'd3);
    check("blk_done",  32'(done_cnt - d0), 32'd1);

    // count=0 with abort raised alongside start in IDLE
    w0 = we_cnt; d0 = done_cnt;
    abort = 1'b1;
    go(32'h00, 32'h40, 6'd0);
    abort = 1'b0;
    check("c0_done", 32'(done), 32'd1);
    check("c0_busy", 32'(busy), 32'd1);
    check("c0_we",   32'(bus_if.mem_we), 32'd0);
    @(negedge clock);
    check("c0_end_done", 32'(done), 32'd0);
    check("c0_end_busy", 32'(busy), 32'd0);
    check("c0_wecnt", 32'(we_cnt - w0), 32'd0);

    // Second start during a 4-word transfer is ignored
    poke(6'd3, 32'h44);
    w0 = we_cnt; d0 = done_cnt;
    go(32'h00, 32'h40, 6'd4);
    @(negedge clock);
    @(negedge clock);
    start = 1'b1; src_addr = 32'h80; dst_addr = 32'h70; count = 6'd1;
    @(negedge clock);
    start = 1'b0;
    wait_idle(60);
    @(negedge clock);
    check("ign_wecnt", 32'(we_cnt - w0), 32'd4);
    check("ign_done",  32'(done_cnt - d0), 32'd1);
    check("ign_mem0",  mem[16], 32'h11);
    check("ign_mem3",  mem[19], 32'h44);

    // Abort during the WR of word 2 of 5
    w0 = we_cnt; d0 = done_cnt; seen = 0;
    go(32'h80, 32'h60, 6'd5);
    for (int n = 0; n < 40; n++) begin
      if (bus_if.mem_we) seen++;
      if (seen == 2) break;
      @(negedge clock);
    end
    check("ab_seen", 32'(seen), 32'd2);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_we",   32'(bus_if.mem_we), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    repeat (5) @(negedge clock);
    check("ab_wecnt", 32'(we_cnt - w0), 32'd2);
    check("ab_donecnt", 32'(done_cnt - d0), 32'd0);
    check("ab_mem1", mem[25], 32'h22);

    // Source pointer wrap and misaligned destination
    poke(6'd63, 32'hCAFE0001);
    go(32'hFFFF_FFFC, 32'h53, 6'd2);
    check("wr_rd1_addr", bus_if.mem_addr, 32'hFFFF_FFFC);
    @(negedge clock);
    @(negedge clock);
    check("wr_wr_addr", bus_if.mem_addr, 32'h50);
    check("wr_wr_data", bus_if.mem_wdata, 32'hCAFE0001);
    @(negedge clock);
    check("wr_rd2_addr", bus_if.mem_addr, 32'h0000_0000);
    wait_idle(20);
    @(negedge clock);
    check("wr_mem1", mem[21], 32'h11);

`ifdef IO_DMA_CHECKSUM_EN
    // Checksum wraps mod 2^32 and clears on the next start
    poke(6'd36, 32'hFFFF_FFFF);
    poke(6'd37, 32'h0000_0002);
    go(32'h90, 32'h20, 6'd2);
    check("cs_clear_start", csum, 32'h0);
    wait_idle(20);
    check("cs_value", csum, 32'h0000_0001);
    go(32'h00, 32'h00, 6'd0);
    check("cs_cleared", csum, 32'h0);
    wait_idle(10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
